// File: rtl/div_pkg.sv
// Shared types and constants for the parametrised restoring divider.
//   div_state_t : control FSM encoding
//   DIV0_Q_FILL : bit replicated across the quotient on divide-by-zero
package div_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } div_state_t;

  localparam logic DIV0_Q_FILL = 1'b1;

endpackage

// File: rtl/div_restoring_step.sv
// One restoring-division iteration (combinational).
// Ports:
//   rem_i     : partial remainder from the previous iteration (always < divisor)
//   bit_i     : next dividend bit shifted into the partial remainder
//   divisor_i : divisor magnitude
//   rem_o     : partial remainder after trial subtraction / restore
//   qbit_o    : quotient bit produced by this iteration
module div_restoring_step #(
  parameter int unsigned VW = 16
) (
  input  logic [VW-1:0] rem_i,
  input  logic          bit_i,
  input  logic [VW-1:0] divisor_i,
  output logic [VW-1:0] rem_o,
  output logic          qbit_o
);

  logic [VW:0]   shifted;
  logic [VW-1:0] diff_lo;

  assign shifted = {rem_i, bit_i};
  // Since rem_i < divisor, a non-negative difference always fits in VW bits,
  // so the low-order subtract is exact whenever it is kept.
  assign diff_lo = shifted[VW-1:0] - divisor_i;
  assign qbit_o  = (shifted >= {1'b0, divisor_i});
  assign rem_o   = qbit_o ? diff_lo : shifted[VW-1:0];

endmodule

// File: rtl/divide_restoring_param.sv
// Parametrised sequential restoring divider: one quotient bit per clock,
// start/busy/ready handshake, divide-by-zero detection.
// Optional signed mode when the macro DIV_SIGNED_EN is defined (adds the
// signed_op port and the FIX state).
// Ports:
//   clock, reset          : rising-edge clock, async active-high reset
//   signed_op             : operands are two's complement (DIV_SIGNED_EN only)
//   start                 : request, sampled while busy=0
//   dividend / divisor    : operands, captured on the accepting edge
//   quotient / remainder  : result, valid while ready=1
//   div0                  : divisor was zero, valid while ready=1
//   ready                 : result valid, held until the next accepted start
//   busy                  : operation in progress
//   count                 : iteration index
module divide_restoring_param
  import div_pkg::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned VW = 16
) (
  input  logic                  clock,
  input  logic                  reset,
`ifdef DIV_SIGNED_EN
  input  logic                  signed_op,
`endif
  input  logic                  start,
  input  logic [DW-1:0]         dividend,
  input  logic [VW-1:0]         divisor,
  output logic [DW-1:0]         quotient,
  output logic [VW-1:0]         remainder,
  output logic                  div0,
  output logic                  ready,
  output logic                  busy,
  output logic [$clog2(DW)-1:0] count
);

  localparam int unsigned CW   = $clog2(DW);
  localparam logic [CW-1:0] LAST = CW'(DW - 1);

  div_state_t    state_q, state_d;
  logic [DW-1:0] quo_q, quo_d;    // dividend shifts out as quotient shifts in
  logic [VW-1:0] rem_q, rem_d;
  logic [VW-1:0] dvs_q, dvs_d;
  logic [CW-1:0] count_q, count_d;
  logic          div0_q, div0_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;

  logic [DW-1:0] dvd_mag;
  logic [VW-1:0] dvs_mag;
  logic          accept_c;
  logic          div_zero_c;
  logic          last_c;
  logic          fix_needed_c;
  logic [VW-1:0] step_rem;
  logic          step_qbit;

`ifdef DIV_SIGNED_EN
  logic sgn_q, sgn_d;
  logic negq_q, negq_d;
  logic negr_q, negr_d;
  logic dvd_neg, dvs_neg;

  // Magnitudes taken at acceptance; most-negative dividend maps onto itself,
  // which is the correct unsigned magnitude.
  assign dvd_neg      = signed_op & dividend[DW-1];
  assign dvs_neg      = signed_op & divisor[VW-1];
  assign dvd_mag      = dvd_neg ? (~dividend) + DW'(1) : dividend;
  assign dvs_mag      = dvs_neg ? (~divisor) + VW'(1) : divisor;
  assign fix_needed_c = sgn_q;
`else
  assign dvd_mag      = dividend;
  assign dvs_mag      = divisor;
  assign fix_needed_c = 1'b0;
`endif

  assign accept_c   = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign div_zero_c = (divisor == '0);
  assign last_c     = (count_q == LAST);

  div_restoring_step #(.VW(VW)) u_step (
    .rem_i     (rem_q),
    .bit_i     (quo_q[DW-1]),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .qbit_o    (step_qbit)
  );

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (accept_c) state_d = div_zero_c ? S_DONE : S_BUSY;
      S_BUSY:         if (last_c) state_d = fix_needed_c ? S_FIX : S_DONE;
      S_FIX:          state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end

  // Datapath / output next values
  always_comb begin
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    count_d = count_q;
    div0_d  = div0_q;
    ready_d = ready_q;
    busy_d  = busy_q;
`ifdef DIV_SIGNED_EN
    sgn_d   = sgn_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept_c) begin
          count_d = '0;
          ready_d = 1'b0;
          dvs_d   = dvs_mag;
          if (div_zero_c) begin
            // Result is loaded now; ready follows one edge later.
            quo_d  = {DW{DIV0_Q_FILL}};
            rem_d  = dividend[VW-1:0];
            div0_d = 1'b1;
            busy_d = 1'b0;
`ifdef DIV_SIGNED_EN
            sgn_d  = 1'b0;
            negq_d = 1'b0;
            negr_d = 1'b0;
`endif
          end else begin
            quo_d  = dvd_mag;
            rem_d  = '0;
            div0_d = 1'b0;
            busy_d = 1'b1;
`ifdef DIV_SIGNED_EN
            sgn_d  = signed_op;
            negq_d = dvd_neg ^ dvs_neg;
            negr_d = dvd_neg;
`endif
          end
        end else if ((state_q == S_DONE) && !ready_q) begin
          ready_d = 1'b1;
        end
      end
      S_BUSY: begin
        quo_d = {quo_q[DW-2:0], step_qbit};
        rem_d = step_rem;
        if (last_c) begin
          if (!fix_needed_c) begin
            busy_d  = 1'b0;
            ready_d = 1'b1;
          end
        end else begin
          count_d = count_q + CW'(1);
        end
      end
`ifdef DIV_SIGNED_EN
      S_FIX: begin
        quo_d   = negq_q ? (~quo_q) + DW'(1) : quo_q;
        rem_d   = negr_q ? (~rem_q) + VW'(1) : rem_q;
        busy_d  = 1'b0;
        ready_d = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      count_q <= '0;
      div0_q  <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef DIV_SIGNED_EN
      sgn_q   <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
`endif
    end else begin
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      count_q <= count_d;
      div0_q  <= div0_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
`ifdef DIV_SIGNED_EN
      sgn_q   <= sgn_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
`endif
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign div0      = div0_q;
  assign ready     = ready_q;
  assign busy      = busy_q;
  assign count     = count_q;

endmodule

// File: tb/tb_divide_restoring_param.sv
// Self-checking bench for divide_restoring_param (DW=32, VW=16).
// Signed cases are included when DIV_SIGNED_EN is defined.
module tb_divide_restoring_param;

  localparam int unsigned DW = 32;
  localparam int unsigned VW = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
`ifdef DIV_SIGNED_EN
  logic          signed_op = 1'b0;
`endif
  logic          start = 1'b0;
  logic [DW-1:0] dividend = '0;
  logic [VW-1:0] divisor = '0;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div0;
  logic          ready;
  logic          busy;
  logic [4:0]    count;

  divide_restoring_param #(.DW(DW), .VW(VW)) dut (
    .clock     (clock),
    .reset     (reset),
`ifdef DIV_SIGNED_EN
    .signed_op (signed_op),
`endif
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .div0      (div0),
    .ready     (ready),
    .busy      (busy),
    .count     (count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] dvd;
    logic [15:0] dvs;
    logic [31:0] q;
    logic [15:0] r;
    logic        d0;
  } vec_t;

  localparam int NVEC = 10;
  vec_t vecs[NVEC];

  int n_chk  = 0;
  int n_fail = 0;

  // Results of the most recent run_op
  int   r_lat;
  logic r_busy_seen;
  logic r_cnt_ok;
  logic r_drop_ok;

  task automatic step_clk();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one operation and wait (bounded) for ready. If inject_at >= 0, a
  // second start with other operands is pulsed while count == inject_at.
  task automatic run_op(input logic [31:0] dvd, input logic [15:0] dvs, input int inject_at);
    int   lat;
    logic bs;
    logic ck;
    dividend = dvd;
    divisor  = dvs;
    start    = 1'b1;
    step_clk();
    start     = 1'b0;
    r_drop_ok = (ready === 1'b0);
    lat = 0;
    bs  = busy;
    ck  = 1'b1;
    if (busy && count !== 5'(lat)) ck = 1'b0;
    while (ready !== 1'b1 && lat < 200) begin
      if (inject_at >= 0 && lat == inject_at) begin
        start    = 1'b1;
        dividend = 32'd9;
        divisor  = 16'd4;
      end else begin
        start = 1'b0;
      end
      step_clk();
      lat++;
      if (busy) bs = 1'b1;
      if (busy && lat < 32 && count !== 5'(lat)) ck = 1'b0;
    end
    start       = 1'b0;
    r_lat       = lat;
    r_busy_seen = bs;
    r_cnt_ok    = ck;
  endtask

  initial begin
    vecs[0] = '{32'h0002_0000, 16'hFFFF, 32'h0000_0002, 16'h0002, 1'b0};
    vecs[1] = '{32'h1234_5678, 16'h0000, 32'hFFFF_FFFF, 16'h5678, 1'b1};
    vecs[2] = '{32'd100,       16'd7,    32'd14,        16'd2,    1'b0};
    vecs[3] = '{32'd9,         16'd4,    32'd2,         16'd1,    1'b0};
    vecs[4] = '{32'hFFFF_FFFF, 16'h0001, 32'hFFFF_FFFF, 16'h0000, 1'b0};
    vecs[5] = '{32'hFFFF_FFFF, 16'hFFFF, 32'h0001_0001, 16'h0000, 1'b0};
    vecs[6] = '{32'd0,         16'd5,    32'd0,         16'd0,    1'b0};
    vecs[7] = '{32'd5,         16'd7,    32'd0,         16'd5,    1'b0};
    vecs[8] = '{32'h8000_0000, 16'h8000, 32'h0001_0000, 16'h0000, 1'b0};
    vecs[9] = '{32'd1000000,   16'd999,  32'd1001,      16'd1,    1'b0};

    // Reset state
    step_clk();
    step_clk();
    check("reset quotient",  64'(quotient),  64'd0);
    check("reset remainder", 64'(remainder), 64'd0);
    check("reset div0",      64'(div0),      64'd0);
    check("reset ready",     64'(ready),     64'd0);
    check("reset busy",      64'(busy),      64'd0);
    check("reset count",     64'(count),     64'd0);
    reset = 1'b0;
    step_clk();

    // Table: each start after the first is issued from DONE
    for (int i = 0; i < NVEC; i++) begin
      run_op(vecs[i].dvd, vecs[i].dvs, -1);
      check($sformatf("vec%0d quotient", i),  64'(quotient),  64'(vecs[i].q));
      check($sformatf("vec%0d remainder", i), 64'(remainder), 64'(vecs[i].r));
      check($sformatf("vec%0d div0", i),      64'(div0),      64'(vecs[i].d0));
      check($sformatf("vec%0d latency", i),   64'(r_lat),     vecs[i].d0 ? 64'd1 : 64'd32);
      check($sformatf("vec%0d ready_drop", i), 64'(r_drop_ok), 64'd1);
      check($sformatf("vec%0d busy", i),      64'(busy),      64'd0);
      if (vecs[i].d0)
        check($sformatf("vec%0d busy_seen", i), 64'(r_busy_seen), 64'd0);
      else
        check($sformatf("vec%0d count_walk", i), 64'(r_cnt_ok), 64'd1);
    end
    check("done count hold", 64'(count), 64'd31);

    // DONE without start holds the result
    repeat (3) step_clk();
    check("done hold ready",    64'(ready),     64'd1);
    check("done hold quotient", 64'(quotient),  64'd1001);
    check("done hold rem",      64'(remainder), 64'd1);

    // Asynchronous reset mid-operation
    begin
      int g;
      dividend = 32'h0002_0000;
      divisor  = 16'hFFFF;
      start    = 1'b1;
      step_clk();
      start = 1'b0;
      g = 0;
      while (count !== 5'd10 && g < 40) begin
        step_clk();
        g++;
      end
      check("midreset reached count 10", 64'(count), 64'd10);
      #2 reset = 1'b1;
      #1;
      check("midreset quotient",  64'(quotient),  64'd0);
      check("midreset remainder", 64'(remainder), 64'd0);
      check("midreset count",     64'(count),     64'd0);
      check("midreset busy",      64'(busy),      64'd0);
      check("midreset ready",     64'(ready),     64'd0);
      check("midreset div0",      64'(div0),      64'd0);
      step_clk();
      reset = 1'b0;
      step_clk();
      run_op(32'd100, 16'd7, -1);
      check("postreset quotient",  64'(quotient),  64'd14);
      check("postreset remainder", 64'(remainder), 64'd2);
      check("postreset latency",   64'(r_lat),     64'd32);
    end

    // start while busy is ignored; operands stay changed until the result
    run_op(32'hFFFF_FFFF, 16'hFFFF, 5);
    check("ignore quotient",  64'(quotient),  64'h0001_0001);
    check("ignore remainder", 64'(remainder), 64'd0);
    check("ignore latency",   64'(r_lat),     64'd32);
    check("ignore count_walk", 64'(r_cnt_ok), 64'd1);

`ifdef DIV_SIGNED_EN
    signed_op = 1'b1;
    run_op(32'hFFFF_FFF9, 16'd2, -1);
    check("signed -7/2 quotient",  64'(quotient),  64'hFFFF_FFFD);
    check("signed -7/2 remainder", 64'(remainder), 64'hFFFF);
    check("signed -7/2 latency",   64'(r_lat),     64'd33);
    run_op(32'h8000_0000, 16'hFFFF, -1);
    check("signed minneg quotient",  64'(quotient),  64'h8000_0000);
    check("signed minneg remainder", 64'(remainder), 64'd0);
    check("signed minneg div0",      64'(div0),      64'd0);
    check("signed minneg latency",   64'(r_lat),     64'd33);
    signed_op = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/divide_restoring_param.md
# divide_restoring_param

Parametrised sequential restoring divider, the general-width successor to the fixed 32/16 unsigned divider. One quotient bit per clock, start/busy/ready handshake, divide-by-zero detection, optional signed mode. Serves as the shared divide resource for datapaths needing any DW/VW split.

## Interface
- DW, 32, dividend and quotient width (≥ 2)
- VW, 16, divisor and remainder width (2 ≤ VW ≤ DW)
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only when busy=0
- dividend  in  DW  numerator, captured on the accepting edge
- divisor  in  VW  denominator, captured on the accepting edge
- signed_op  in  1  treat operands as two's complement (present only with DIV_SIGNED_EN)
- quotient  out  DW  result, valid while ready=1
- remainder  out  VW  result, valid while ready=1
- div0  out  1  divisor was zero; valid while ready=1
- ready  out  1  result valid; held until the next accepted start
- busy  out  1  operation in progress
- count  out  $clog2(DW)  iteration index during BUSY

## Operation
- States: IDLE, BUSY, FIX (only with DIV_SIGNED_EN), DONE.
- Reset (any time, including mid-operation): state=IDLE; quotient, remainder, count, div0, ready, busy all 0. The operation in flight is discarded.
- IDLE/DONE + start=1: operands registered; divisor==0 → DONE next edge with quotient=all ones, remainder=dividend[VW-1:0], div0=1. Otherwise → BUSY, count=0, ready=0, div0=0.
- BUSY: partial remainder is VW+1 bits. Each edge: shift in the next dividend MSB; trial-subtract the divisor; if non-negative keep the difference and set the quotient bit to 1, else restore and set it to 0. count increments. After the iteration at count=DW-1, go to DONE (or FIX when signed).
- start while busy=1: ignored, no effect on the operation.
- start while in DONE: accepted exactly as in IDLE. ready drops on the same edge.
- Result for divisor≠0: quotient = floor(dividend/divisor); remainder < divisor.

## Timing
- Accepting edge E0. Unsigned: busy=1 after E0, ready=1 and busy=0 after E0+DW.
- Signed: ready after E0+DW+1, because FIX adds one cycle.
- Divide-by-zero: ready after E0+1; busy stays 0 throughout.
- count reads 0..DW-1 across the BUSY cycles and holds DW-1 in FIX/DONE.
- Outputs are registered only; there is no combinational path from inputs to outputs.

## Configuration
- DIV_SIGNED_EN defined: the signed_op port exists.
- With signed_op=1, operands are converted to magnitudes at acceptance.
- FIX negates the quotient when the operand signs differ. The remainder takes the sign of the dividend.
- Most-negative dividend / −1 returns quotient = most-negative value (wraps) and remainder 0, with no flag.
- DIV_SIGNED_EN undefined: no signed_op port, no FIX state, unsigned only.

## Structure
- Package div_pkg holds: the state enum (div_state_t) and the DIV0 quotient fill constant.
- Sub-module div_restoring_step is combinational. Inputs: partial remainder, incoming bit, divisor. Outputs: next remainder and quotient bit. The top instantiates it once.

## Test plan
- DW=32, VW=16: 0x0002_0000 / 0xFFFF → quotient 0x0000_0002, remainder 0x0002, div0=0; ready exactly 32 edges after the accepting edge; count walks 0x00..0x1F.
- 0x1234_5678 / 0x0000 → quotient 0xFFFF_FFFF, remainder 0x5678, div0=1; ready after 1 edge; busy never asserted.
- Reset asserted asynchronously at count=0x0A → all outputs 0 immediately. A following 100 / 7 → quotient 14, remainder 2.
- start pulsed again at count=5 with other operands → ignored; the original result is returned on time.
- start asserted in the DONE state with 9 / 4 → ready drops on that edge; result quotient 2, remainder 1 after 32 edges.
- Signed (DIV_SIGNED_EN, signed_op=1):
  - −7 / 2 → quotient 0xFFFF_FFFD, remainder 0xFFFF, after 33 edges.
  - 0x8000_0000 / 0xFFFF → quotient 0x8000_0000, remainder 0.
